tcdm_bank_array_ctrl: RTL

//  Parametrised L1 TCDM bank array: NB_BANKS independent single-port banks of

---
 rtl/tcdm_bank_array_ctrl.sv | 209 ++++++++++++++++++++
 1 files changed

// File: rtl/tcdm_bank_array_ctrl.sv
// -----------------------------------------------------------------------------
// tcdm_bank_array_ctrl
// L1 TCDM bank array: NB_BANKS independent single-port banks of DATA_WIDTH bits
// with byte enables, each behind a req/gnt/rvalid handshake. After reset, every
// word is zeroed by a sweep, unless INIT_ZERO=0 or test_mode_i is set. Reads can
// optionally go through an extra output register. A power-down/wake FSM holds
// off grants while the array is asleep or waking up.
//
// Ports (AW = $clog2(BANK_SIZE), BE_WIDTH = DATA_WIDTH/8)
//   clk_i        clock
//   rst_ni       synchronous active-low reset
//   test_mode_i  skip the zero-init sweep
//   pwdn_i       power-down request (level)
//   req_i        per-bank request            [NB_BANKS]
//   we_i         per-bank write enable       [NB_BANKS]
//   addr_i       per-bank word address       [NB_BANKS*AW]
//   wdata_i      per-bank write data         [NB_BANKS*DATA_WIDTH]
//   be_i         per-bank byte enables       [NB_BANKS*BE_WIDTH]
//   gnt_o        per-bank grant, combinational on req_i
//   rvalid_o     per-bank read data valid, 1+RD_PIPE cycles after grant
//   rdata_o      per-bank read data, held between reads
//   init_done_o  sticky flag, set on the first entry to ACTIVE after reset
//   sleep_o      high while in SLEEP
// -----------------------------------------------------------------------------
module tcdm_bank_array_ctrl #(
  parameter int NB_BANKS    = 16,
  parameter int BANK_SIZE   = 1024,
  parameter int DATA_WIDTH  = 32,
  parameter int RD_PIPE     = 0,
  parameter int INIT_ZERO   = 1,
  parameter int WAKE_CYCLES = 4,
  localparam int AW       = $clog2(BANK_SIZE),
  localparam int BE_WIDTH = DATA_WIDTH / 8
) (
  input  logic                           clk_i,
  input  logic                           rst_ni,
  input  logic                           test_mode_i,
  input  logic                           pwdn_i,
  input  logic [NB_BANKS-1:0]            req_i,
  input  logic [NB_BANKS-1:0]            we_i,
  input  logic [NB_BANKS*AW-1:0]         addr_i,
  input  logic [NB_BANKS*DATA_WIDTH-1:0] wdata_i,
  input  logic [NB_BANKS*BE_WIDTH-1:0]   be_i,
  output logic [NB_BANKS-1:0]            gnt_o,
  output logic [NB_BANKS-1:0]            rvalid_o,
  output logic [NB_BANKS*DATA_WIDTH-1:0] rdata_o,
  output logic                           init_done_o,
  output logic                           sleep_o
);

  // One counter serves both the init sweep and the wake delay, so it has to
  // cover whichever of the two ranges is larger.
  localparam int CNT_MAX = (BANK_SIZE > WAKE_CYCLES) ? BANK_SIZE : WAKE_CYCLES;
  localparam int CW      = $clog2(CNT_MAX + 1);

  typedef enum logic [1:0] {
    ST_INIT   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_SLEEP  = 2'd2,
    ST_WAKE   = 2'd3
  } state_e;

  state_e              state, state_next;
  logic [CW-1:0]       cnt, cnt_next;
  logic                init_we;
  logic                rd_busy;
  logic [NB_BANKS-1:0] s1_valid;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state       <= ST_INIT;
      cnt         <= '0;
      init_done_o <= 1'b0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
      if (state == ST_INIT && state_next == ST_ACTIVE) begin
        init_done_o <= 1'b1;
      end
    end
  end

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    init_we    = 1'b0;
    case (state)
      ST_INIT: begin
        if (INIT_ZERO == 0 || test_mode_i) begin
          state_next = ST_ACTIVE;
        end else begin
          init_we = 1'b1;
          if (cnt == CW'(BANK_SIZE - 1)) begin
            state_next = ST_ACTIVE;
          end else begin
            cnt_next = cnt + CW'(1);
          end
        end
      end
      ST_ACTIVE: begin
        // Reads already granted must deliver their data before the array sleeps.
        if (pwdn_i && !rd_busy) begin
          state_next = ST_SLEEP;
        end
      end
      ST_SLEEP: begin
        if (!pwdn_i) begin
          state_next = ST_WAKE;
          cnt_next   = '0;
        end
      end
      ST_WAKE: begin
        if (pwdn_i) begin
          state_next = ST_SLEEP;
        end else if (cnt == CW'(WAKE_CYCLES - 1)) begin
          state_next = ST_ACTIVE;
        end else begin
          cnt_next = cnt + CW'(1);
        end
      end
      default: state_next = ST_INIT;
    endcase
  end

  assign gnt_o   = (state == ST_ACTIVE && !pwdn_i) ? req_i : '0;
  assign sleep_o = (state == ST_SLEEP);

  // The output register stage already presents its data, so only the first
  // stage counts as in flight, and only when a second stage exists.
  assign rd_busy = (RD_PIPE != 0) && (|s1_valid);

  for (genvar b = 0; b < NB_BANKS; b++) begin : g_bank
    logic [DATA_WIDTH-1:0] mem [BANK_SIZE];
    logic [AW-1:0]         addr;
    logic [DATA_WIDTH-1:0] wdata;
    logic [BE_WIDTH-1:0]   be;
    logic                  in_range;
    logic                  wr_en;
    logic                  rd_en;
    logic                  s1_valid_q;
    logic [DATA_WIDTH-1:0] s1_data_q;

    assign addr  = addr_i[b*AW +: AW];
    assign wdata = wdata_i[b*DATA_WIDTH +: DATA_WIDTH];
    assign be    = be_i[b*BE_WIDTH +: BE_WIDTH];

    // With a power-of-two depth every address decodes to a word.
    if ((1 << AW) == BANK_SIZE) begin : g_full
      assign in_range = 1'b1;
    end else begin : g_partial
      assign in_range = ({1'b0, addr} < (AW + 1)'(BANK_SIZE));
    end

    assign wr_en = rst_ni & gnt_o[b] & we_i[b] & in_range;
    assign rd_en = gnt_o[b] & ~we_i[b];

    // Storage has no reset; contents survive reset and sleep.
    always_ff @(posedge clk_i) begin
      if (rst_ni && init_we) begin
        mem[cnt[AW-1:0]] <= '0;
      end else if (wr_en) begin
        for (int i = 0; i < BE_WIDTH; i++) begin
          if (be[i]) begin
            mem[addr][i*8 +: 8] <= wdata[i*8 +: 8];
          end
        end
      end
    end

    // Read data only updates on a read, so it holds the last value otherwise.
    always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
        s1_valid_q <= 1'b0;
        s1_data_q  <= '0;
      end else begin
        s1_valid_q <= rd_en;
        if (rd_en) begin
          s1_data_q <= in_range ? mem[addr] : '0;
        end
      end
    end

    assign s1_valid[b] = s1_valid_q;

    if (RD_PIPE != 0) begin : g_pipe
      logic                  out_valid_q;
      logic [DATA_WIDTH-1:0] out_data_q;

      always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
          out_valid_q <= 1'b0;
          out_data_q  <= '0;
        end else begin
          out_valid_q <= s1_valid_q;
          if (s1_valid_q) begin
            out_data_q <= s1_data_q;
          end
        end
      end

      assign rvalid_o[b]                           = out_valid_q;
      assign rdata_o[b*DATA_WIDTH +: DATA_WIDTH] = out_data_q;
    end else begin : g_nopipe
      assign rvalid_o[b]                           = s1_valid_q;
      assign rdata_o[b*DATA_WIDTH +: DATA_WIDTH] = s1_data_q;
    end
  end

endmodule
